// File: rtl/video_timing_probe.sv
// video_timing_probe: recovers pixel/line position and per-frame geometry from raw blank/sync timing
module video_timing_probe #(
  parameter int W = 10,
  parameter bit SYNC_LOW = 1'b1
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         ce_pix,
  input  logic         hblank,
  input  logic         vblank,
  input  logic         hsync,
  input  logic         vsync,
  output logic [W-1:0] hpos,
  output logic [W-1:0] vpos,
  output logic [W-1:0] htotal,
  output logic [W-1:0] hactive,
  output logic [W-1:0] hsync_start,
  output logic [W-1:0] hsync_width,
  output logic [W-1:0] vtotal,
  output logic [W-1:0] vactive,
  output logic [W-1:0] vsync_start,
  output logic [W-1:0] vsync_width,
  output logic         valid,
  output logic         changed,
  output logic         frame_start
);
  typedef enum logic [1:0] {IDLE, FIRST, MEASURED, LOCKED} state_t;
  localparam logic [W-1:0] MAX = '1;
  state_t state_q, state_d, next_fs;
  logic primed_q, hblank_q, vsync_q, vbl_ls_q, hs_seen_q, vs_seen_q;
  logic hblank_d, vsync_d, vbl_ls_d, hs_seen_d, vs_seen_d;
  logic [W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [W-1:0] hact_q, hact_d, hss_q, hss_d, hsw_q, hsw_d;
  logic [W-1:0] vact_q, vact_d, vss_q, vss_d, vsw_q, vsw_d;
  logic [7:0][W-1:0] geo_q, geo_d, snap_q;
  logic valid_q, changed_q, changed_d, fs_q;
  logic hs_on, vs_on, ls, fs, vs_edge, tmo;
  function automatic logic [W-1:0] inc(input logic [W-1:0] v, input logic en);
    return (en && v != MAX) ? v + W'(1) : v;
  endfunction
  always_comb begin
    hs_on = SYNC_LOW ? ~hsync : hsync;
    vs_on = SYNC_LOW ? ~vsync : vsync;
    ls = ce_pix & primed_q & hblank_q & ~hblank;
    fs = ls & ~vblank & vbl_ls_q;
    vs_edge = ce_pix & primed_q & vs_on & ~vsync_q;
    hblank_d = ce_pix ? hblank : hblank_q;
    vsync_d = ce_pix ? vs_on : vsync_q;
    vbl_ls_d = ls ? vblank : vbl_ls_q;
    hpos_d = ce_pix ? (ls ? '0 : inc(hpos_q, 1'b1)) : hpos_q;
    vpos_d = fs ? '0 : ls ? inc(vpos_q, 1'b1) : vpos_q;
    hact_d = ce_pix ? inc(ls ? '0 : hact_q, ~hblank) : hact_q;
    hsw_d = ce_pix ? inc(ls ? '0 : hsw_q, hs_on) : hsw_q;
    hss_d = (ce_pix & hs_on & (ls | ~hs_seen_q)) ? hpos_d : ls ? '0 : hss_q;
    hs_seen_d = ce_pix ? (hs_on | (hs_seen_q & ~ls)) : hs_seen_q;
    vact_d = ls ? inc(fs ? '0 : vact_q, ~vblank) : vact_q;
    vsw_d = ls ? inc(fs ? '0 : vsw_q, vs_on) : vsw_q;
    vss_d = (vs_edge & (fs | ~vs_seen_q)) ? vpos_d : fs ? '0 : vss_q;
    vs_seen_d = vs_edge | (vs_seen_q & ~fs);
    geo_d = {fs ? {vsw_q, vss_q, vact_q, vpos_q + W'(1)} : geo_q[7:4],
             ls ? {hsw_q, hss_q, hact_q, hpos_q + W'(1)} : geo_q[3:0]};
    tmo = ce_pix & (hpos_d == MAX | vpos_d == MAX);
    next_fs = state_q == IDLE ? FIRST : state_q == FIRST ? MEASURED : geo_d == snap_q ? LOCKED : MEASURED;
    state_d = tmo ? IDLE : fs ? next_fs : state_q;
    changed_d = fs & ~tmo & (state_q == LOCKED) & (geo_d != snap_q);
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      primed_q <= 1'b0;
      hblank_q <= 1'b0;
      vsync_q <= 1'b0;
      vbl_ls_q <= 1'b0;
      hs_seen_q <= 1'b0;
      vs_seen_q <= 1'b0;
      hpos_q <= '0;
      vpos_q <= '0;
      hact_q <= '0;
      hss_q <= '0;
      hsw_q <= '0;
      vact_q <= '0;
      vss_q <= '0;
      vsw_q <= '0;
      geo_q <= '0;
      snap_q <= '0;
      valid_q <= 1'b0;
      changed_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      primed_q <= primed_q | ce_pix;
      hblank_q <= hblank_d;
      vsync_q <= vsync_d;
      vbl_ls_q <= vbl_ls_d;
      hs_seen_q <= hs_seen_d;
      vs_seen_q <= vs_seen_d;
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      hact_q <= hact_d;
      hss_q <= hss_d;
      hsw_q <= hsw_d;
      vact_q <= vact_d;
      vss_q <= vss_d;
      vsw_q <= vsw_d;
      geo_q <= geo_d;
      snap_q <= fs ? geo_d : snap_q;
      valid_q <= state_d == LOCKED;
      changed_q <= changed_d;
      fs_q <= fs;
    end
  end
  assign hpos = hpos_q;
  assign vpos = vpos_q;
  assign {vsync_width, vsync_start, vactive, vtotal, hsync_width, hsync_start, hactive, htotal} = geo_q;
  assign valid = valid_q;
  assign changed = changed_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_video_timing_probe.sv
// tb_video_timing_probe: directed checks of position, geometry, lock, mode change, timeout and reset
module tb_video_timing_probe;
  localparam int W = 10;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce_pix = 1'b0;
  logic hblank = 1'b1;
  logic vblank = 1'b1;
  logic hsync = 1'b1;
  logic vsync = 1'b1;
  logic [W-1:0] hpos, vpos, htotal, hactive, hsync_start, hsync_width;
  logic [W-1:0] vtotal, vactive, vsync_start, vsync_width;
  logic valid, changed, frame_start;
  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int ch_cnt = 0;
  int gap = 8;
  int cfg [8];
  int f_fs, f_ch;
  logic f_valid;
  logic [W-1:0] f_hpos, f_vpos;
  logic [W-1:0] f_geo [8];
  string names [8] = '{"htotal", "hactive", "hsync_start", "hsync_width", "vtotal", "vactive", "vsync_start", "vsync_width"};
  video_timing_probe #(.W(W), .SYNC_LOW(1'b1)) dut (
    .clk_sys(clk), .reset(reset), .ce_pix(ce_pix),
    .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .hpos(hpos), .vpos(vpos),
    .htotal(htotal), .hactive(hactive), .hsync_start(hsync_start), .hsync_width(hsync_width),
    .vtotal(vtotal), .vactive(vactive), .vsync_start(vsync_start), .vsync_width(vsync_width),
    .valid(valid), .changed(changed), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    fs_cnt += int'(frame_start);
    ch_cnt += int'(changed);
  end
  task automatic pix(input logic hb, input logic vb, input logic hs, input logic vs);
    hblank = hb;
    vblank = vb;
    hsync = ~hs;
    vsync = ~vs;
    ce_pix = 1'b1;
    @(posedge clk);
    #2;
    if (gap > 1) begin
      ce_pix = 1'b0;
      repeat (gap - 1) @(posedge clk);
      #2;
    end
  endtask
  task automatic frame(input int nl);
    int f0, c0;
    f0 = fs_cnt;
    c0 = ch_cnt;
    for (int l = 0; l < nl; l++)
      for (int p = 0; p < cfg[0]; p++) begin
        pix(p >= cfg[1], l >= cfg[5], p >= cfg[2] && p < cfg[2] + cfg[3], l >= cfg[6] && l < cfg[6] + cfg[7]);
        if (l == 0 && p == 0) begin
          f_fs = fs_cnt - f0;
          f_ch = ch_cnt - c0;
          f_valid = valid;
          f_hpos = hpos;
          f_vpos = vpos;
          f_geo = '{htotal, hactive, hsync_start, hsync_width, vtotal, vactive, vsync_start, vsync_width};
        end
      end
  endtask
  task automatic test_reset(input string tag);
    logic [W-1:0] g [8];
    ce_pix = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    g = '{htotal, hactive, hsync_start, hsync_width, vtotal, vactive, vsync_start, vsync_width};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (g[i] !== '0) begin errors++; $display("FAIL %s_%s got %0d want 0", tag, names[i], g[i]); end
    end
    checks++;
    if (hpos !== '0 || vpos !== '0) begin errors++; $display("FAIL %s_pos got %0d/%0d want 0/0", tag, hpos, vpos); end
    checks++;
    if ({valid, changed, frame_start} !== 3'b000) begin errors++; $display("FAIL %s_flags got %b want 000", tag, {valid, changed, frame_start}); end
  endtask
  task automatic test_lock(input string tag);
    frame(cfg[4]);
    checks++;
    if (f_fs !== 0) begin errors++; $display("FAIL %s_prime_fs got %0d want 0", tag, f_fs); end
    for (int k = 1; k <= 2; k++) begin
      frame(cfg[4]);
      checks++;
      if (f_fs !== 1 || f_valid !== 1'b0) begin errors++; $display("FAIL %s_fs%0d got fs=%0d valid=%b want fs=1 valid=0", tag, k, f_fs, f_valid); end
    end
    frame(cfg[4]);
    checks++;
    if (f_fs !== 1 || f_valid !== 1'b1 || f_ch !== 0) begin errors++; $display("FAIL %s_lock got fs=%0d valid=%b changed=%0d want 1/1/0", tag, f_fs, f_valid, f_ch); end
    checks++;
    if (f_hpos !== '0 || f_vpos !== '0) begin errors++; $display("FAIL %s_pos_at_fs got %0d/%0d want 0/0", tag, f_hpos, f_vpos); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (f_geo[i] !== W'(cfg[i])) begin errors++; $display("FAIL %s_%s got %0d want %0d", tag, names[i], f_geo[i], cfg[i]); end
    end
  endtask
  task automatic test_mode_change;
    cfg[0] = 22;
    frame(cfg[4]);
    checks++;
    if (f_valid !== 1'b1 || f_ch !== 0 || f_geo[0] !== W'(20)) begin errors++; $display("FAIL mode_first got valid=%b changed=%0d htotal=%0d want 1/0/20", f_valid, f_ch, f_geo[0]); end
    frame(cfg[4]);
    checks++;
    if (f_valid !== 1'b0 || f_ch !== 1 || f_geo[0] !== W'(22)) begin errors++; $display("FAIL mode_change got valid=%b changed=%0d htotal=%0d want 0/1/22", f_valid, f_ch, f_geo[0]); end
    frame(cfg[4]);
    checks++;
    if (f_valid !== 1'b1 || f_ch !== 0 || f_geo[0] !== W'(22)) begin errors++; $display("FAIL mode_relock got valid=%b changed=%0d htotal=%0d want 1/0/22", f_valid, f_ch, f_geo[0]); end
  endtask
  task automatic test_timeout;
    gap = 1;
    frame(1);
    checks++;
    if (f_valid !== 1'b1) begin errors++; $display("FAIL timeout_pre got valid=%b want 1", f_valid); end
    repeat (1001) pix(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b1 || hpos !== W'(1022)) begin errors++; $display("FAIL timeout_edge got valid=%b hpos=%0d want 1/1022", valid, hpos); end
    pix(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b0 || hpos !== W'(1023)) begin errors++; $display("FAIL timeout_hit got valid=%b hpos=%0d want 0/1023", valid, hpos); end
    checks++;
    if (htotal !== W'(22) || hactive !== W'(12) || hsync_start !== W'(14) || vtotal !== W'(12)) begin
      errors++;
      $display("FAIL timeout_hold got %0d/%0d/%0d/%0d want 22/12/14/12", htotal, hactive, hsync_start, vtotal);
    end
    pix(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (valid !== 1'b0 || hpos !== W'(1023)) begin errors++; $display("FAIL timeout_sat got valid=%b hpos=%0d want 0/1023", valid, hpos); end
  endtask
  task automatic test_reset_mid;
    gap = 2;
    cfg = '{20, 12, 14, 3, 12, 8, 9, 2};
    frame(5);
    checks++;
    if (hpos !== W'(19)) begin errors++; $display("FAIL reset_mid_hpos got %0d want 19", hpos); end
    test_reset("reset_mid");
    test_lock("reset_mid");
  endtask
  task automatic test_simul_edges;
    cfg[2] = 0;
    frame(cfg[4]);
    frame(cfg[4]);
    checks++;
    if (f_geo[2] !== '0 || f_geo[3] !== W'(3)) begin errors++; $display("FAIL simul_hsync got start=%0d width=%0d want 0/3", f_geo[2], f_geo[3]); end
    checks++;
    if (f_geo[0] !== W'(20) || f_geo[1] !== W'(12)) begin errors++; $display("FAIL simul_htotal got %0d/%0d want 20/12", f_geo[0], f_geo[1]); end
    checks++;
    if (f_ch !== 1 || f_valid !== 1'b0) begin errors++; $display("FAIL simul_changed got changed=%0d valid=%b want 1/0", f_ch, f_valid); end
  endtask
  task automatic test_continuous;
    gap = 1;
    cfg = '{20, 12, 14, 3, 12, 8, 9, 2};
    test_reset("cont_reset");
    test_lock("continuous");
  endtask
  initial begin
    cfg = '{20, 12, 14, 3, 12, 8, 9, 2};
    test_reset("reset");
    test_lock("nominal");
    test_mode_change;
    test_timeout;
    test_reset_mid;
    test_simul_edges;
    test_continuous;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
